// File: rtl/systolic_result_collector.sv
// systolic_result_collector
// Captures one result from each PE of the systolic grid as its valid arrives.
// It flags PEs that report twice and aborts if the grid takes too long. Once
// every PE has reported, it streams the results in index order over a
// valid/ready port and then pulses done.
module systolic_result_collector #(
  parameter  int N       = 3,
  parameter  int DW      = 16,
  parameter  int TIMEOUT = 64,
  localparam int NP      = N * N,
  localparam int IW      = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NP-1:0]    pe_valid,
  input  logic [NP*DW-1:0] pe_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [IW-1:0]    out_idx,
  output logic             done,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_dup
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [NP-1:0]     r_mask;
  logic [DW-1:0]     r_buf [NP];
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_done;
  logic              r_errTimeout;
  logic              r_errDup;

  logic [NP-1:0]     w_maskNext;
  logic              w_complete;
  logic              w_dup;
  logic              w_timeoutHit;
  logic              w_handshake;
  logic              w_lastIdx;

  // The mask after this cycle's captures, and the events that steer the FSM.
  // A PE that has already been captured cannot change the mask, so OR-ing in
  // the raw valids gives the same result as OR-ing in only the new captures.
  always_comb begin
    w_maskNext   = r_mask | pe_valid;
    w_complete   = &w_maskNext;
    w_dup        = |(pe_valid & r_mask);
    w_timeoutHit = (r_cnt == CW'(TIMEOUT - 1));
    w_handshake  = (r_state == S_DRAIN) && out_ready;
    w_lastIdx    = (r_idx == IW'(NP - 1));
  end

  // Result buffer: the first valid from each PE during COLLECT is stored.
  // Later valids from that PE leave it untouched. The buffer has no reset
  // because its contents only matter once the mask says they are captured.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (r_state == S_COLLECT && pe_valid[i] && !r_mask[i]) begin
        r_buf[i] <= pe_data[i*DW +: DW];
      end
    end
  end

  // Control FSM with capture mask, timeout counter, drain index and flags.
  // When the mask completes on the final allowed cycle, completion takes
  // priority over the timeout abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_done       <= 1'b0;
      r_errTimeout <= 1'b0;
      r_errDup     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_COLLECT;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_errTimeout <= 1'b0;
            r_errDup     <= 1'b0;
          end
        end
        S_COLLECT: begin
          r_mask <= w_maskNext;
          r_cnt  <= r_cnt + CW'(1);
          if (w_dup) begin
            r_errDup <= 1'b1;
          end
          if (w_complete) begin
            r_state <= S_DRAIN;
            r_idx   <= '0;
          end else if (w_timeoutHit) begin
            r_errTimeout <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_handshake) begin
            if (w_lastIdx) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs come only from registers. out_data is forced to zero outside
  // DRAIN so that the uninitialised buffer never shows on the port.
  always_comb begin
    out_valid   = (r_state == S_DRAIN);
    busy        = (r_state != S_IDLE);
    out_idx     = r_idx;
    out_data    = (r_state == S_DRAIN) ? r_buf[r_idx] : '0;
    done        = r_done;
    err_timeout = r_errTimeout;
    err_dup     = r_errDup;
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector
// Random and directed collection runs against a queue-based reference model.
// A separate monitor compares every streamed result against that model.
module tb_systolic_result_collector;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int TO = 10;
  localparam int NP = N * N;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NP-1:0]    pe_valid;
  logic [NP*DW-1:0] pe_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             done;
  logic             busy;
  logic             err_timeout;
  logic             err_dup;

  int errors = 0;
  int checks = 0;
  int readyMode = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t             expQ [$];
  logic [NP-1:0]    vecValid [$];
  logic [NP*DW-1:0] vecData [$];
  logic             expDup;
  logic             expTimeout;

  systolic_result_collector #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .pe_valid(pe_valid), .pe_data(pe_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .done(done), .busy(busy),
    .err_timeout(err_timeout), .err_dup(err_dup)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NP*DW-1:0] randData();
    logic [NP*DW-1:0] d;
    for (int i = 0; i < NP; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic pushVec(input logic [NP-1:0] v);
    vecValid.push_back(v);
    vecData.push_back(randData());
  endtask

  // Models the collection from the stimulus table and pushes the expected
  // results. It then drives start and one table row per COLLECT cycle.
  task automatic applyStimulus();
    logic [NP-1:0] seen;
    logic [DW-1:0] got [NP];
    bit            dup;
    bit            complete;
    int            lastK;
    while (vecValid.size() < TO) pushVec('0);
    seen = '0; dup = 0; complete = 0; lastK = TO - 1;
    for (int k = 0; k < TO; k++) begin
      for (int i = 0; i < NP; i++) begin
        if (vecValid[k][i]) begin
          if (seen[i]) dup = 1;
          else begin
            seen[i] = 1'b1;
            got[i] = vecData[k][i*DW +: DW];
          end
        end
      end
      if (&seen) begin
        complete = 1; lastK = k; break;
      end
    end
    expDup = dup;
    expTimeout = !complete;
    if (complete) for (int i = 0; i < NP; i++) expQ.push_back('{idx: IW'(i), data: got[i]});

    @(posedge clk) #1;
    start = 1'b1; pe_valid = NP'($urandom); pe_data = randData();
    for (int k = 0; k <= lastK; k++) begin
      @(posedge clk) #1;
      start = ($urandom_range(0, 3) == 0);
      pe_valid = vecValid[k];
      pe_data = vecData[k];
      @(negedge clk);
      checkOutput("busyCollect", busy, 1);
      checkOutput("validCollect", out_valid, 0);
      if (k == 0) checkOutput("errClearedOnStart", {err_dup, err_timeout}, 0);
    end
    @(posedge clk) #1;
    start = 1'b0; pe_valid = NP'($urandom); pe_data = randData();
    @(negedge clk);
    if (complete) checkOutput("drainEntry", {busy, out_valid, out_idx}, {1'b1, 1'b1, IW'(0)});
    else checkOutput("timeoutExit", {busy, out_valid, err_timeout}, 3'b001);
    vecValid.delete();
    vecData.delete();
  endtask

  task automatic waitIdle();
    int vc = 0;
    bit ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) begin ok = 1; break; end
      if (out_valid) vc++;
      @(negedge clk);
    end
    checkOutput("idleReached", ok, 1);
    if (readyMode == 0 && !expTimeout) checkOutput("drainCycles", vc, NP);
    checkOutput("errDup", err_dup, expDup);
    checkOutput("errTimeout", err_timeout, expTimeout);
    checkOutput("queueEmpty", expQ.size(), 0);
  endtask

  task automatic waitHandshakeAt(input int idx, output bit ok);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_ready && out_idx == IW'(idx)) begin ok = 1; break; end
      @(negedge clk);
    end
    checkOutput("handshakeReached", ok, 1);
  endtask

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
  initial begin
    int ph = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk) #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = (ph % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Monitor: checks ordered results, stable data while stalled, done timing.
  initial begin
    bit prevStall = 0;
    bit pendDone = 0;
    logic [IW-1:0] pIdx;
    logic [DW-1:0] pData;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 0; pendDone = 0;
      end else begin
        checkOutput("donePulse", done, pendDone);
        if (done) checkOutput("validLowAtDone", out_valid, 0);
        pendDone = 0;
        if (prevStall) checkOutput("stallHold", {out_valid, out_idx, out_data}, {1'b1, pIdx, pData});
        prevStall = 0;
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) checkOutput("unexpectedOut", out_valid, 0);
          else begin
            e = expQ.pop_front();
            checkOutput("outIdx", out_idx, e.idx);
            checkOutput("outData", out_data, e.data);
            if (e.idx == IW'(NP - 1)) pendDone = 1;
          end
        end else if (out_valid) begin
          prevStall = 1; pIdx = out_idx; pData = out_data;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized batch.
  initial begin
    logic [NP*DW-1:0] d;
    bit ok;
    rst = 1'b1; start = 1'b0; pe_valid = '0; pe_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetOutputs", {out_valid, done, busy, err_timeout, err_dup, out_idx, out_data}, 0);
    @(posedge clk) #1;
    rst = 1'b0;

    $display("[TB] nominal one PE per cycle");
    for (int k = 0; k < NP; k++) pushVec(NP'(1) << k);
    applyStimulus(); waitIdle();

    $display("[TB] wavefront");
    pushVec('1);
    applyStimulus(); waitIdle();

    $display("[TB] backpressure");
    readyMode = 1;
    pushVec(9'h011); pushVec(9'h102); pushVec(9'h0a4); pushVec(9'h048);
    applyStimulus(); waitIdle();
    readyMode = 0;

    $display("[TB] duplicate on PE 4");
    pushVec(9'h003); pushVec(9'h00c);
    d = randData(); d[4*DW +: DW] = 16'h1111;
    vecValid.push_back(9'h010); vecData.push_back(d);
    d = randData(); d[4*DW +: DW] = 16'h2222;
    vecValid.push_back(9'h030); vecData.push_back(d);
    pushVec(9'h0c0); pushVec(9'h100);
    applyStimulus(); waitIdle();

    $display("[TB] timeout");
    for (int k = 0; k < NP - 1; k++) pushVec(NP'(1) << k);
    applyStimulus(); waitIdle();

    $display("[TB] completion on final allowed cycle");
    for (int k = 0; k < NP - 1; k++) pushVec(NP'(1) << k);
    pushVec('0); pushVec(9'h100);
    applyStimulus(); waitIdle();

    $display("[TB] final bits together with duplicate");
    pushVec(9'h0ff); pushVec(9'h101);
    applyStimulus(); waitIdle();

    $display("[TB] back-to-back start on done cycle");
    pushVec(9'h1f0); pushVec(9'h00f);
    applyStimulus();
    waitHandshakeAt(NP - 1, ok);
    checkOutput("errDupB2b", err_dup, expDup);
    pushVec('1);
    applyStimulus(); waitIdle();

    $display("[TB] reset mid-drain");
    for (int k = 0; k < NP; k++) pushVec(NP'(1) << k);
    applyStimulus();
    waitHandshakeAt(3, ok);
    @(posedge clk) #1;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    checkOutput("midResetOutputs", {out_valid, done, busy, err_timeout, err_dup, out_idx, out_data}, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    pushVec(9'h155); pushVec(9'h0aa);
    applyStimulus(); waitIdle();

    $display("[TB] randomized runs");
    for (int t = 0; t < 20; t++) begin
      readyMode = 2;
      for (int k = 0; k < TO; k++) pushVec(NP'($urandom) & NP'($urandom));
      applyStimulus(); waitIdle();
    end
    readyMode = 0;

    repeat (3) @(negedge clk);
    checkOutput("finalQueueEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
